// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush scheduler: stall vectors,
// FSM state encodings and stage bit positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_EXWAIT = 2'd1,
    PC_FLUSH  = 2'd2
  } pc_state_e;

  localparam int STAGE_PC   = 0;
  localparam int STAGE_IF   = 1;
  localparam int STAGE_ID   = 2;
  localparam int STAGE_EX   = 3;
  localparam int STAGE_MEM  = 4;
  localparam int STAGE_WB   = 5;
  localparam int NUM_STAGES = 6;

  // A stall at stage k must also freeze every stage upstream of it.
  function automatic logic [NUM_STAGES-1:0] stall_upto(input int top);
    logic [NUM_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i <= top) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  localparam logic [NUM_STAGES-1:0] STALL_NONE = '0;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = stall_upto(STAGE_ID);
  localparam logic [NUM_STAGES-1:0] STALL_EX   = stall_upto(STAGE_EX);
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = stall_upto(STAGE_MEM);

  localparam int FCNT_W = 3;

endpackage

// File: rtl/pipe_ctrl_dcnt.sv
// Loadable, freezable down-counter; holds at zero rather than wrapping.
module pipe_ctrl_dcnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         is_one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler with multi-cycle EX sequencing.
// Optional stalled-cycle counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start,
  input  logic [CNT_W-1:0] ex_len,
  input  logic             mem_wait,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [31:0]      perf_stall_cnt
);

  pc_state_e        state;
  logic             cnt_one;
  logic             fcnt_one;
  logic             ex_accept;
  logic             ex_short;
  logic             ex_enter;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_en;
  logic [5:0]       stall_raw;

  // The ex_start cycle is itself the first stalled cycle, so EXWAIT only has
  // to cover ex_len-2 further cycles; a length-2 op finishes in its start cycle.
  assign ex_accept = rst && (state == PC_RUN) && ex_start && !mem_wait &&
                     !flush_req && (ex_len >= CNT_W'(2));
  assign ex_short  = (ex_len == CNT_W'(2));
  assign ex_enter  = ex_accept && !ex_short;

  assign cnt_load  = flush_req || ex_enter;
  assign cnt_value = flush_req ? '0 : (ex_len - CNT_W'(2));
  assign cnt_en    = (state == PC_EXWAIT) && !mem_wait;

  pipe_ctrl_dcnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .value  (cnt_value),
    .en     (cnt_en),
    .is_one (cnt_one)
  );

  pipe_ctrl_dcnt #(.W(FCNT_W)) u_fcnt (
    .clk    (clk),
    .rst    (rst),
    .load   (flush_req),
    .value  (FCNT_W'(FLUSH_CYCLES)),
    .en     (state == PC_FLUSH),
    .is_one (fcnt_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PC_RUN;
    end else if (flush_req) begin
      state <= PC_FLUSH;
    end else begin
      case (state)
        PC_RUN:    if (ex_enter) state <= PC_EXWAIT;
        PC_EXWAIT: if (cnt_one && !mem_wait) state <= PC_RUN;
        PC_FLUSH:  if (fcnt_one) state <= PC_RUN;
        default:   state <= PC_RUN;
      endcase
    end
  end

  always_comb begin
    stall_raw = STALL_NONE;
    if (state == PC_FLUSH) begin
      stall_raw = STALL_NONE;
    end else if (mem_wait) begin
      stall_raw = STALL_MEM;
    end else if ((state == PC_EXWAIT) || ex_accept) begin
      stall_raw = STALL_EX;
    end else if (stallreq_id) begin
      stall_raw = STALL_ID;
    end
  end

  // Requests are not registered, so reset must mask them to keep outputs quiet.
  assign stall   = rst ? stall_raw : STALL_NONE;
  assign flush   = (state == PC_FLUSH);
  assign ex_busy = (state == PC_EXWAIT);
  assign ex_done = ((state == PC_EXWAIT) && cnt_one && !mem_wait && !flush_req) ||
                   (ex_accept && ex_short);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if ((stall != STALL_NONE) && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed steps then random traffic,
// compared against a cycle-count model of the scheduling rules.
module tb_pipe_ctrl;

  localparam int FC    = 2;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_id;
  logic             ex_start;
  logic [CNT_W-1:0] ex_len;
  logic             mem_wait;
  logic             flush_req;
  logic [5:0]       stall;
  logic             flush;
  logic             ex_busy;
  logic             ex_done;
  logic [31:0]      perf_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: remaining stalled EX cycles after the start cycle,
  // remaining flush cycles, and stalled cycles seen so far.
  int          m_ex_left;
  int          m_fl_left;
  logic [31:0] m_perf;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .ex_start       (ex_start),
    .ex_len         (ex_len),
    .mem_wait       (mem_wait),
    .flush_req      (flush_req),
    .stall          (stall),
    .flush          (flush),
    .ex_busy        (ex_busy),
    .ex_done        (ex_done),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp();
`ifdef PIPE_CTRL_PERF_EN
    return m_perf;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".stall"},   {26'd0, stall}, 32'd0);
    check({tag, ".flush"},   {31'd0, flush}, 32'd0);
    check({tag, ".ex_busy"}, {31'd0, ex_busy}, 32'd0);
    check({tag, ".ex_done"}, {31'd0, ex_done}, 32'd0);
    check({tag, ".perf"},    perf_stall_cnt, 32'd0);
  endtask

  task automatic model_reset();
    m_ex_left = 0;
    m_fl_left = 0;
    m_perf    = 32'd0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic id, input logic st, input int len,
                      input logic mw, input logic fr);
    logic [5:0] e_stall;
    logic       e_flush, e_busy, e_done, acc;
    stallreq_id = id;
    ex_start    = st;
    ex_len      = CNT_W'(len);
    mem_wait    = mw;
    flush_req   = fr;
    @(negedge clk);
    acc = 1'b0; e_stall = 6'b0; e_flush = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_fl_left > 0) begin
      e_flush = 1'b1;
    end else if (m_ex_left > 0) begin
      e_busy  = 1'b1;
      e_stall = mw ? 6'b011111 : 6'b001111;
      e_done  = !mw && (m_ex_left == 1) && !fr;
    end else begin
      acc     = st && !mw && !fr && (len >= 2);
      e_stall = mw ? 6'b011111 : acc ? 6'b001111 : id ? 6'b000111 : 6'b000000;
      e_done  = acc && (len == 2);
    end
    check("stall",   {26'd0, stall},   {26'd0, e_stall});
    check("flush",   {31'd0, flush},   {31'd0, e_flush});
    check("ex_busy", {31'd0, ex_busy}, {31'd0, e_busy});
    check("ex_done", {31'd0, ex_done}, {31'd0, e_done});
    check("perf",    perf_stall_cnt,   perf_exp());
    @(posedge clk);
    if ((e_stall != 6'b0) && (m_perf != 32'hFFFF_FFFF)) m_perf = m_perf + 32'd1;
    if (fr) begin
      m_fl_left = FC;
      m_ex_left = 0;
    end else if (m_fl_left > 0) begin
      m_fl_left--;
    end else if (m_ex_left > 0) begin
      if (!mw) m_ex_left--;
    end else if (acc) begin
      m_ex_left = len - 2;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stallreq_id = 1'b0; ex_start = 1'b0; ex_len = '0; mem_wait = 1'b0; flush_req = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] exp10;
    int          r, len;

    do_reset();

    // ID interlock for two cycles.
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // Plain 5-cycle EX op.
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    idle(5);

    // 5-cycle op with a 2-cycle memory wait in the middle.
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(5);

    // Flush in the second EXWAIT cycle cancels the op.
    step(1'b0, 1'b1, 8, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(4);

    // Flush wins over a simultaneous start; length-1 op never stalls.
    step(1'b0, 1'b1, 5, 1'b0, 1'b1);
    idle(4);
    step(1'b0, 1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(2);

    // Flush re-requested while flushing; mem_wait ignored during flush.
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(3);

    // Exactly ten stalled cycles after a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
`ifdef PIPE_CTRL_PERF_EN
    exp10 = 32'd10;
`else
    exp10 = 32'd0;
`endif
    check("perf_after_10", perf_stall_cnt, exp10);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      len = (r < 2) ? r : r + 1;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, len,
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    idle(12);

    // Asynchronous reset mid-EXWAIT with requests still raised.
    step(1'b0, 1'b1, 10, 1'b0, 1'b0);
    idle(2);
    check("pre_reset_busy", {31'd0, ex_busy}, 32'd1);
    stallreq_id = 1'b1;
    mem_wait    = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_quiet("async_reset");
    @(posedge clk);
    #1;
    check_quiet("reset_held");
    @(negedge clk);
    rst = 1'b1;
    stallreq_id = 1'b0; mem_wait = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 4, 1'b0, 1'b0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
